ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the Y86 shell to the keyboard on the same two-wire bus the keyboard receiver listens on. It runs the PS/2 request-to-send sequence, shifts the byte out on device-generated clocks, checks the device ACK and reports done or error. The open-drain pads are outside this block; it only produces pull-low enables and reads the synchronised line levels.

## Interface
- INHIBIT_CYCLES, 10000: number of SYS_CLK cycles the clock line is held low before request-to-send (100 µs at 100 MHz); minimum 2.
- TIMEOUT_CYCLES, 2000000: SYS_CLK cycles allowed from clock release to ACK (20 ms at 100 MHz).
- SYS_CLK  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready on a SYS_CLK edge.
- tx_done  out  1  one-cycle pulse: byte ACKed and bus idle.
- tx_err  out  1  one-cycle pulse: no ACK or timeout.
- busy  out  1  high from accept until done/err pulse inclusive.
- ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock line low.
- ps2_data_oe  out  1  1 = pull data line low.

## Operation
- Both raw lines go through 2-flop synchronisers; a falling edge ("fe") is synced-previous=1 and synced-current=0.
- Odd parity: parity bit = ~^tx_data.
- Frame bits, indexed by fe count k: k=1..8 data bits 0..7 LSB first, k=9 parity, k=10 stop (released = 1), k=11 ACK sampled.
- Driving a bit b: ps2_data_oe = ~b.
- States:
  - IDLE: oe both 0, tx_ready=1. On accept, latch byte, parity, go INHIBIT, clear counter.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles; ps2_data_oe=1 asserted in the last cycle; then REQ.
  - REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); start timeout counter; k=0; go SHIFT.
  - SHIFT: on each fe, increment k and drive bit k per frame map; at k=10 release data; at k=11 sample synced data: 0 → WAIT_IDLE, 1 → ERR.
  - WAIT_IDLE: oe both 0; when synced clock and data both 1 → DONE.
  - DONE: pulse tx_done, go IDLE. ERR: pulse tx_err, oe both 0, go IDLE.
- Timeout: counter runs from REQ until ACK sampled; reaching TIMEOUT_CYCLES in SHIFT or WAIT_IDLE → ERR.
- tx_valid while not ready is ignored; tx_data changes after accept have no effect.
- fe seen in INHIBIT or IDLE is ignored.

## Timing
- All outputs registered. Reset values: tx_ready=0, tx_done=0, tx_err=0, busy=0, ps2_clk_oe=0, ps2_data_oe=0; state IDLE; tx_ready=1 the first cycle after reset deasserts.
- Accept cycle N: busy=1, tx_ready=0, ps2_clk_oe=1 from N+1.
- ps2_clk_oe high for exactly INHIBIT_CYCLES cycles; ps2_data_oe rises 1 cycle before ps2_clk_oe falls.
- Bit change: ps2_data_oe updates 3 SYS_CLK cycles after the raw ps2_clk_in falling edge (2 sync + 1 register).
- tx_done/tx_err: exactly one cycle, mutually exclusive; tx_ready returns high the cycle after the pulse; an accept can occur that same cycle.
- Reset mid-frame: both oe deassert the cycle after reset is sampled; no done/err pulse.

## Test plan
- Reset: assert reset 3 cycles mid-SHIFT -> oe both 0 next cycle, tx_ready=1 after release, no pulses.
- Send 0xED (INHIBIT_CYCLES=20), device model clocks 11 fe and pulls data low at fe 11 -> ps2_clk_oe high 20 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop released; tx_done pulse once lines idle.
- Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0, tx_done; back-to-back accept of 0xFF in the tx_ready cycle after done -> second frame starts, parity 1.
- No ACK: device leaves data high at fe 11 -> tx_err pulse, no tx_done, oe both 0.
- Timeout (TIMEOUT_CYCLES=5000): device stops after 4 fe -> tx_err at cycle 5000 after REQ, lines released.
- tx_valid held during busy with changing tx_data -> ignored, frame carries latched byte only.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 device. It inhibits the bus (clock held
// low), issues request-to-send (data low, clock released), shifts the byte
// out LSB first on device-generated clock falling edges, adds odd parity
// and a released stop bit, then checks the device ACK.
// The open-drain pads live outside; this block only produces pull-low
// enables and reads the raw line levels through 2-flop synchronisers.
//
// Ports:
//   SYS_CLK      in   system clock (only clock)
//   reset        in   synchronous active-high reset
//   tx_data[7:0] in   command byte, sampled on accept
//   tx_valid     in   request to send tx_data
//   tx_ready     out  high only while idle; accept = tx_valid & tx_ready
//   tx_done      out  one-cycle pulse: byte ACKed and bus idle again
//   tx_err       out  one-cycle pulse: missing ACK or timeout
//   busy         out  high from accept through the done/err pulse
//   ps2_clk_in   in   raw PS/2 clock line level (asynchronous)
//   ps2_data_in  in   raw PS/2 data line level (asynchronous)
//   ps2_clk_oe   out  1 = pull clock line low
//   ps2_data_oe  out  1 = pull data line low
//
// All outputs are registered.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       SYS_CLK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // One counter serves both the inhibit interval and the ACK timeout,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       frame_q, frame_d;

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_prev_q;

  logic             tx_ready_q, tx_done_q, tx_err_q, busy_q;
  logic             clk_oe_q, data_oe_q;
  logic             ready_d, busy_d, done_d, err_d;
  logic             clk_oe_d, data_oe_d;

  logic             clk_fe_s;
  logic             accept_s;

  // Line synchronisers; the bus idles high, so reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_fe_s = clk_prev_q & ~clk_sync_q[1];
  assign accept_s = tx_valid & tx_ready_q;

  // State, counters and latched frame.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 4'd0;
      frame_q   <= 9'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
    end
  end

  // Next state plus next values of every registered output. Outputs are
  // computed from the next state so they appear in the same cycle as it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_INHIBIT;
          frame_d  = {odd_parity(tx_data), tx_data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end

      ST_INHIBIT: begin
        // cnt_q counts inhibit cycles already shown; data is pulled low
        // during the final inhibit cycle so it leads the clock release.
        cnt_d    = cnt_q + CNT_ONE;
        clk_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          state_d   = ST_REQ;
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end else if (cnt_q == INH_PRE) begin
          data_oe_d = 1'b1;
        end else begin
          data_oe_d = 1'b0;
        end
      end

      ST_REQ: begin
        // Start bit (0) is already on the line; timeout count began at 0.
        state_d   = ST_SHIFT;
        cnt_d     = cnt_q + CNT_ONE;
        bit_cnt_d = 4'd0;
        data_oe_d = 1'b1;
      end

      ST_SHIFT: begin
        cnt_d     = cnt_q + CNT_ONE;
        data_oe_d = data_oe_q;
        if (cnt_q == TO_LAST) begin
          state_d   = ST_ERR;
          err_d     = 1'b1;
          data_oe_d = 1'b0;
        end else if (clk_fe_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd9) begin
            // Edges 1..9: data bits LSB first, then parity.
            data_oe_d = ~frame_q[0];
            frame_d   = {1'b1, frame_q[8:1]};
          end else if (bit_cnt_q == 4'd9) begin
            // Edge 10: stop bit, line released.
            data_oe_d = 1'b0;
          end else begin
            // Edge 11: device ACK is a low data line.
            data_oe_d = 1'b0;
            if (!data_sync_q[1]) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (clk_sync_q[1] && data_sync_q[1]) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Registered outputs; reset releases both lines and suppresses pulses.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      tx_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      tx_ready_q <= ready_d;
      tx_done_q  <= done_d;
      tx_err_q   <= err_d;
      busy_q     <= busy_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
